uart_imem_loader: RTL

- Serial program loader upstream of instruction fetch.
- Receives an 8N1 UART byte stream, packs it into little-endian 32-bit words and writes them to instruction memory from word address 0.
- Holds the CPU in reset while loading; the board top muxes its write port into the instruction ROM.
- Lets the team reload programs without re-synthesising the bitstream.

---
 rtl/uart_imem_loader_pkg.sv | 26 ++
 rtl/uart_imem_loader_rx.sv | 110 +++++++++++
 rtl/uart_imem_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
//   REGWIDTH   : instruction word width written to memory
//   ld_state_e : main load sequencer states
//   rx_state_e : UART receiver states
package uart_imem_loader_pkg;

  localparam int unsigned REGWIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, bit timer and receive FSM.
// Ports:
//   clk, rst    : clock, async active-high reset
//   rx_in       : raw serial line (idle high, asynchronous)
//   byte_valid  : one-cycle pulse, byte_data holds the received byte
//   byte_data   : received byte, LSB first on the line
//   frame_err   : one-cycle pulse when the stop bit is sampled low
module uart_rx
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             bv_q, bv_d;
  logic             fe_q, fe_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !sync2_q) state_d = RX_START;
      // Mid-start-bit sample: a high line here was a glitch, not a start bit
      RX_START: if (cnt_q == HALF_M1) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_q == BIT_M1 && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_q == BIT_M1) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Bit timer, shift register and result strobes
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      RX_START: if (cnt_q == HALF_M1) cnt_d = '0;
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          bv_d  = sync2_q;
          fe_d  = !sync2_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers; synchroniser presets to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_valid = bv_q;
  assign byte_data  = shift_q;
  assign frame_err  = fe_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Serial program loader: receives a 16-bit little-endian word count N
// followed by N little-endian 32-bit words over UART and writes them to
// instruction memory from word address 0, holding the CPU in reset meanwhile.
// Ports:
//   clk, rst      : clock, async active-high reset
//   load_start    : one-cycle pulse, starts a load from IDLE/DONE/ERR
//   uart_rx       : serial line (idle high, asynchronous)
//   imem_we       : one-cycle write strobe
//   imem_addr     : word address of the write
//   imem_wdata    : word to write
//   cpu_hold      : CPU reset hold while loading / after an error
//   done, error   : terminal status flags
//   words_loaded  : words written so far in this load
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned TIMEOUT_CLKS = 10000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [REGWIDTH-1:0]   imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (uart_rx),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  ld_state_e               state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [23:0]             buf_q, buf_d;
  logic [1:0]              lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     words_q, words_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    we_q, we_d;
  logic [REGWIDTH-1:0]     wdata_q, wdata_d;
  logic                    hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic        waiting_c;
  logic        tmo_hit_c;
  logic [15:0] len_full_c;
  logic        last_word_c;

  // Inter-byte timeout applies only while waiting on the line; a byte wins a tie
  assign waiting_c   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                       (state_q == ST_DATA);
  assign tmo_hit_c   = waiting_c && !rx_valid && (tmo_q == TMO_LAST);
  assign len_full_c  = {rx_data, len_q[7:0]};
  // words_q increments in the same edge that leaves WRITE
  assign last_word_c = (32'(words_q) + 32'd1) == 32'(len_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (load_start) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (rx_ferr)       state_d = ST_ERR;
        else if (rx_valid) state_d = ST_LEN_HI;
        else if (tmo_hit_c) state_d = ST_ERR;
      end
      ST_LEN_HI: begin
        if (rx_ferr) state_d = ST_ERR;
        else if (rx_valid) begin
          if (len_full_c == 16'd0)                state_d = ST_DONE;
          else if (32'(len_full_c) > MAX_WORDS)   state_d = ST_ERR;
          else                                    state_d = ST_DATA;
        end else if (tmo_hit_c) state_d = ST_ERR;
      end
      ST_DATA: begin
        if (rx_ferr)                          state_d = ST_ERR;
        else if (rx_valid && lane_q == 2'd3)  state_d = ST_WRITE;
        else if (tmo_hit_c)                   state_d = ST_ERR;
      end
      ST_WRITE: begin
        if (rx_ferr)          state_d = ST_ERR;
        else if (last_word_c) state_d = ST_DONE;
        else                  state_d = ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    len_d   = len_q;
    buf_d   = buf_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    words_d = words_q;
    tmo_d   = tmo_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          addr_d  = '0;
          words_d = '0;
          lane_d  = '0;
          tmo_d   = '0;
        end
      end
      ST_LEN_LO: begin
        tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
        if (rx_valid) len_d[7:0] = rx_data;
      end
      ST_LEN_HI: begin
        tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
        if (rx_valid) len_d[15:8] = rx_data;
      end
      ST_DATA: begin
        tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
        if (rx_valid) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              // 4th byte completes the word straight into the write register
              we_d    = 1'b1;
              wdata_d = {rx_data, buf_q};
            end
          endcase
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
      end
      default: ;
    endcase
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
    hold_d = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
             (state_q == ST_DATA)   || (state_q == ST_WRITE)  ||
             (state_q == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      buf_q   <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      buf_q   <= buf_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule
